vsource_capture_ctrl: RTL
=========================

// Module: vsource_capture_ctrl
// PURPOSE
//  Sequencer and frame-capture controller for the virtual signal source.
//  Holds the host-side pulse/noise configuration and applies it only at pulse-period boundaries.
//  Drives the source enable and arms a triggered capture of the filtered output.
//  Stores a frame with pre-trigger history in a dual-port RAM for host readback.
// PARAMETERS
//  FRAME_LEN   1024  samples per captured frame (power of 2)
//  PRE_LEN     128   pre-trigger samples per frame (< FRAME_LEN)
//  DW          18    sample width, signed
// PORTS
//  clk            in   1   single system clock
//  rst            in   1   synchronous, active-high reset
//  run            in   1   level; 1 = source enabled
//  cfg_period     in   16  staged pulse period
//  cfg_width      in   16  staged pulse width
//  cfg_amplitude  in   16  staged pulse amplitude
//  cfg_noise      in   16  staged noise amplitude
//  cfg_load       in   1   pulse; stage cfg_* for application
//  arm            in   1   pulse; start a capture
//  abort          in   1   pulse; cancel capture, return to IDLE
//  auto_rearm     in   1   level; re-arm automatically after DONE
//  vs_enable      out  1   to source enable
//  vs_period      out  16  to source pulse_period (also width/amplitude/noise, same style)
//  vs_width, vs_amplitude, vs_noise  out  16 each
//  vs_trig        in   1   source trig_out, 1-cycle pulse
//  vs_dv          in   1   source dv_out
//  vs_d           in   DW  source d_out
//  rd_addr        in   log2(FRAME_LEN)  frame read index, 0 = oldest sample
//  rd_data        out  DW  RAM data, 1-cycle latency
//  state          out  2   0 IDLE, 1 PRETRIG, 2 ARMED, 3 CAPTURE (DONE reported as IDLE with frame_valid)
//  frame_valid    out  1   a complete frame is readable
//  frame_done     out  1   1-cycle pulse at capture completion
//  frame_count    out  16  completed frames, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, state IDLE, staged and active config 0.
//  Config:
//   - cfg_load latches cfg_* into the staging registers.
//   - Staged values copy to vs_* on the cycle after cfg_load when vs_enable=0.
//   - Otherwise they copy on the cycle after the next vs_trig.
//   - cfg_load and vs_trig in the same cycle: the new values apply after the next vs_trig, not this one.
//  vs_enable: registered copy of run, 1-cycle latency.
//  Write pointer:
//   - wptr advances mod FRAME_LEN on every vs_dv while state != IDLE.
//   - RAM writes vs_d at wptr.
//  FSM:
//   - IDLE->PRETRIG on arm when vs_enable=1. Arm is ignored when vs_enable=0.
//     Arm clears frame_valid and pre_cnt.
//   - PRETRIG counts vs_dv samples and moves to ARMED when pre_cnt reaches PRE_LEN.
//     A vs_trig seen in PRETRIG is ignored.
//   - ARMED: vs_trig sets trig_pend.
//     The first vs_dv with trig_pend set (same cycle counts) is frame index PRE_LEN.
//     On that sample: record start = wptr-PRE_LEN mod FRAME_LEN, post_cnt = 1, go to CAPTURE.
//   - CAPTURE: count vs_dv. When post_cnt reaches FRAME_LEN-PRE_LEN:
//     frame_valid=1, frame_done pulse, frame_count++, then go IDLE.
//     If auto_rearm=1, go PRETRIG instead of IDLE.
//   - vs_trig during CAPTURE is ignored; no retrigger.
//   - abort: in any state, go IDLE next cycle; trig_pend clears; frame_valid is unchanged.
//   - run dropping mid-capture: treated as abort.
//   - arm while not IDLE: ignored.
//   - abort and arm in the same cycle: abort wins.
//  Readback:
//   - Physical address = start + rd_addr mod FRAME_LEN.
//   - rd_data is valid one cycle after rd_addr.
//   - Contents are undefined when frame_valid=0.
//   - The host must not read during PRETRIG/ARMED/CAPTURE after auto-rearm; data is being overwritten.
//  Arithmetic: all pointers and counters are unsigned and wrap modulo FRAME_LEN. Samples are stored unmodified.
// STRUCTURE
//  - vsource_pkg: FRAME_LEN default, sample_t (logic signed [DW-1:0]), cap_state_t enum.
//  - Sub-module vsource_frame_ram: simple dual-port RAM, one write port, one registered read port.
// TESTING
//  1. run=1, cfg period=99/width=4/amp=1000/noise=0, arm
//     -> frame_done once; rd_addr 0..127 = baseline 0; pulse rise at index >= 128; frame_count=1.
//  2. cfg_load with width=8 while enabled
//     -> vs_width changes the cycle after the next vs_trig, never mid-period.
//  3. vs_trig during PRETRIG, then none for 200 samples
//     -> state stays ARMED; no capture until the next trig.
//  4. abort in CAPTURE at post_cnt=300
//     -> state IDLE next cycle; no frame_done; frame_count unchanged.
//  5. auto_rearm=1 over 3 periods
//     -> frame_count=3; each capture shows PRETRIG before ARMED.
//  6. rst asserted mid-CAPTURE
//     -> all outputs 0 next cycle; arm right after rst release is honoured once run=1.

Source files
------------

// File: rtl/vsource_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vsource_pkg
// Description : Shared defaults, sample type and capture state encoding for
//               the virtual signal source capture controller.
// Revision    : 1.0  initial release
// ============================================================================
package vsource_pkg;

    localparam int c_FRAME_LEN_DFLT = 1024;
    localparam int c_PRE_LEN_DFLT   = 128;
    localparam int c_DW             = 18;

    typedef logic signed [c_DW-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRETRIG = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/vsource_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vsource_capture_ctrl_if
// Description : Controller <-> virtual source link: enable and pulse/noise
//               settings out, trigger and sample stream back.
// Revision    : 1.0  initial release
// ============================================================================
interface vsource_capture_ctrl_if
    import vsource_pkg::*;
#(
    parameter int DW = c_DW
);
    logic                 vs_enable;
    logic [15:0]          vs_period;
    logic [15:0]          vs_width;
    logic [15:0]          vs_amplitude;
    logic [15:0]          vs_noise;
    logic                 vs_trig;
    logic                 vs_dv;
    logic signed [DW-1:0] vs_d;

    modport master (
        output vs_enable, vs_period, vs_width, vs_amplitude, vs_noise,
        input  vs_trig, vs_dv, vs_d
    );

    modport slave (
        input  vs_enable, vs_period, vs_width, vs_amplitude, vs_noise,
        output vs_trig, vs_dv, vs_d
    );

endinterface
`default_nettype wire

// File: rtl/vsource_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : vsource_frame_ram
// Description : Simple dual-port frame buffer, one write port and one
//               registered read port (1-cycle read latency).
// Revision    : 1.0  initial release
// ============================================================================
module vsource_frame_ram
    import vsource_pkg::*;
#(
    parameter int DEPTH = c_FRAME_LEN_DFLT,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = c_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] r_mem [DEPTH];
    logic signed [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents stay undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vsource_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vsource_capture_ctrl
// Description : Sequencer for the virtual signal source: period-aligned
//               config hand-over, source enable and triggered frame capture
//               with pre-trigger history into a readback RAM.
// Revision    : 1.0  initial release
// ============================================================================
module vsource_capture_ctrl
    import vsource_pkg::*;
#(
    parameter int FRAME_LEN = c_FRAME_LEN_DFLT,
    parameter int PRE_LEN   = c_PRE_LEN_DFLT,
    parameter int DW        = c_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [15:0]                  cfg_period,
    input  logic [15:0]                  cfg_width,
    input  logic [15:0]                  cfg_amplitude,
    input  logic [15:0]                  cfg_noise,
    input  logic                         cfg_load,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         auto_rearm,
    vsource_capture_ctrl_if.master       vs,
    input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
    output logic signed [DW-1:0]         rd_data,
    output logic [1:0]                   state,
    output logic                         frame_valid,
    output logic                         frame_done,
    output logic [15:0]                  frame_count
);

    localparam int            c_AW        = $clog2(FRAME_LEN);
    localparam logic [c_AW-1:0] c_PRE_OFS  = c_AW'(PRE_LEN);
    localparam logic [c_AW-1:0] c_PRE_LAST = c_AW'(PRE_LEN - 1);
    localparam logic [c_AW-1:0] c_POST_LAST = c_AW'(FRAME_LEN - PRE_LEN - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    cap_state_t      r_state;
    cap_state_t      w_state_nxt;

    logic            r_vs_enable;
    logic [15:0]     r_stg_period, r_stg_width, r_stg_amplitude, r_stg_noise;
    logic [15:0]     r_vs_period, r_vs_width, r_vs_amplitude, r_vs_noise;
    logic            r_cfg_pend;

    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_start;
    logic [c_AW-1:0] r_pre_cnt;
    logic [c_AW-1:0] r_post_cnt;
    logic            r_trig_pend;
    logic            r_frame_valid;
    logic            r_frame_done;
    logic [15:0]     r_frame_count;

    logic            w_stop;
    logic            w_trig_hit;
    logic            w_wr;
    logic            w_arm_ok;
    logic            w_cap_start;
    logic            w_cap_end;
    logic [c_AW-1:0] w_rd_phys;

    // ------------------------------------------------------------------
    // Source enable and period-aligned configuration hand-over
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_enable     <= 1'b0;
            r_stg_period    <= '0;
            r_stg_width     <= '0;
            r_stg_amplitude <= '0;
            r_stg_noise     <= '0;
            r_vs_period     <= '0;
            r_vs_width      <= '0;
            r_vs_amplitude  <= '0;
            r_vs_noise      <= '0;
            r_cfg_pend      <= 1'b0;
        end else begin
            r_vs_enable <= run;
            if (cfg_load) begin
                r_stg_period    <= cfg_period;
                r_stg_width     <= cfg_width;
                r_stg_amplitude <= cfg_amplitude;
                r_stg_noise     <= cfg_noise;
                // A trigger coinciding with the load belongs to the old values.
                if (!r_vs_enable) begin
                    r_vs_period    <= cfg_period;
                    r_vs_width     <= cfg_width;
                    r_vs_amplitude <= cfg_amplitude;
                    r_vs_noise     <= cfg_noise;
                    r_cfg_pend     <= 1'b0;
                end else begin
                    r_cfg_pend     <= 1'b1;
                end
            end else if (r_cfg_pend && (vs.vs_trig || !r_vs_enable)) begin
                r_vs_period    <= r_stg_period;
                r_vs_width     <= r_stg_width;
                r_vs_amplitude <= r_stg_amplitude;
                r_vs_noise     <= r_stg_noise;
                r_cfg_pend     <= 1'b0;
            end
        end
    end

    assign vs.vs_enable    = r_vs_enable;
    assign vs.vs_period    = r_vs_period;
    assign vs.vs_width     = r_vs_width;
    assign vs.vs_amplitude = r_vs_amplitude;
    assign vs.vs_noise     = r_vs_noise;

    // ------------------------------------------------------------------
    // Capture FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_arm_ok    = 1'b0;
        w_cap_start = 1'b0;
        w_cap_end   = 1'b0;
        w_stop      = abort || !r_vs_enable;
        w_trig_hit  = r_trig_pend || vs.vs_trig;
        w_wr        = vs.vs_dv && (r_state != ST_IDLE);

        if (r_state == ST_IDLE) begin
            if (arm && r_vs_enable && !abort) begin
                w_state_nxt = ST_PRETRIG;
                w_arm_ok    = 1'b1;
            end
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_PRETRIG: begin
                    if (vs.vs_dv && (r_pre_cnt == c_PRE_LAST)) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (vs.vs_dv && w_trig_hit) begin
                        w_state_nxt = ST_CAPTURE;
                        w_cap_start = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (vs.vs_dv && (r_post_cnt == c_POST_LAST)) begin
                        w_cap_end   = 1'b1;
                        w_state_nxt = auto_rearm ? ST_PRETRIG : ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture datapath: pointers, counters and frame status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_start       <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_trig_pend   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_cap_end;

            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end

            if (w_arm_ok || (w_cap_end && auto_rearm)) begin
                r_pre_cnt <= '0;
            end else if ((r_state == ST_PRETRIG) && vs.vs_dv) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end

            // Pending trigger lives only inside ARMED and dies with the capture start.
            r_trig_pend <= (r_state == ST_ARMED) && !w_stop && !w_cap_start && w_trig_hit;

            if (w_cap_start) begin
                r_start    <= r_wptr - c_PRE_OFS;
                r_post_cnt <= c_AW'(1);
            end else if ((r_state == ST_CAPTURE) && vs.vs_dv) begin
                r_post_cnt <= r_post_cnt + 1'b1;
            end

            if (w_arm_ok) begin
                r_frame_valid <= 1'b0;
            end else if (w_cap_end) begin
                r_frame_valid <= 1'b1;
            end

            if (w_cap_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer; readback index 0 is the oldest sample of the frame
    // ------------------------------------------------------------------
    assign w_rd_phys = r_start + rd_addr;

    vsource_frame_ram #(
        .DEPTH (FRAME_LEN),
        .AW    (c_AW),
        .DW    (DW)
    ) u_frame_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr),
        .waddr (r_wptr),
        .wdata (vs.vs_d),
        .raddr (w_rd_phys),
        .rdata (rd_data)
    );

    assign state       = r_state;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
